// File: rtl/sync_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with clamped parallel load, count enable,
// combinational terminal count and a registered wrap/saturation-hit pulse.
module sync_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 10,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // MODULUS-1 always fits in WIDTH bits, even when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_d;
    logic             wrap_d;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_VAL);
    assign at_zero = (q == '0);
    assign tc      = en & ~load & ((up & at_max) | (~up & at_zero));

    // End-of-range is detected by compare, so q+1 / q-1 are only taken when they stay in range.
    always_comb begin
        q_d    = q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = (d > MAX_VAL) ? MAX_VAL : d;
        end else if (en) begin
            wrap_d = tc;
            if (up) begin
                if (!at_max) begin
                    q_d = q + 1'b1;
                end else if (!SATURATE) begin
                    q_d = '0;
                end
            end else begin
                if (!at_zero) begin
                    q_d = q - 1'b1;
                end else if (!SATURATE) begin
                    q_d = MAX_VAL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_d;
            wrap <= wrap_d;
        end
    end

endmodule

// File: tb/tb_sync_mod_counter.sv
// Bench for sync_mod_counter: three configurations (mod-10 wrap, mod-10 saturate, full-range
// mod-8) driven in lockstep and checked against an arithmetic reference model.
module tb_sync_mod_counter;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] d;
    logic [3:0] q0, q1;
    logic [2:0] q2;
    logic       tc0, tc1, tc2;
    logic       w0, w1, w2;

    int checks   = 0;
    int failures = 0;
    int mq[3];

    typedef struct {
        bit       e;
        bit       u;
        bit       l;
        logic [3:0] dv;
        int       eq;
        int       etc;
        int       ew;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d),
        .q(q0), .tc(tc0), .wrap(w0)
    );

    sync_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d),
        .q(q1), .tc(tc1), .wrap(w1)
    );

    sync_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_full (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d[2:0]),
        .q(q2), .tc(tc2), .wrap(w2)
    );

    function automatic int mod_of(input int i);
        return (i == 2) ? 8 : 10;
    endfunction

    function automatic int dut_q(input int i);
        case (i)
            0:       return int'(q0);
            1:       return int'(q1);
            default: return int'(q2);
        endcase
    endfunction

    function automatic int dut_tc(input int i);
        case (i)
            0:       return int'(tc0);
            1:       return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    function automatic int dut_w(input int i);
        case (i)
            0:       return int'(w0);
            1:       return int'(w1);
            default: return int'(w2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit e, input bit u, input bit l, input logic [3:0] dv,
                                input int eq, input int etc, input int ew);
        vec_t v;
        v.e = e; v.u = u; v.l = l; v.dv = dv; v.eq = eq; v.etc = etc; v.ew = ew;
        return v;
    endfunction

    // One clock: apply inputs, check tc before the edge, check q/wrap after it, advance model.
    task automatic cycle(input bit e, input bit u, input bit l, input logic [3:0] dv,
                         output int tc_pre0);
        int nq[3];
        int et[3];
        en = e; up = u; load = l; d = dv;
        #2;
        tc_pre0 = int'(tc0);
        for (int i = 0; i < 3; i++) begin
            int m;
            int dl;
            bit sat;
            m   = mod_of(i);
            sat = (i == 1);
            dl  = (i == 2) ? int'(dv[2:0]) : int'(dv);
            et[i] = (e && !l && (u ? (mq[i] == m - 1) : (mq[i] == 0))) ? 1 : 0;
            check($sformatf("tc[%0d]", i), dut_tc(i), et[i]);
            if (l)        nq[i] = (dl > m - 1) ? m - 1 : dl;
            else if (!e)  nq[i] = mq[i];
            else if (u)   nq[i] = sat ? ((mq[i] + 1 > m - 1) ? m - 1 : mq[i] + 1)
                                      : (mq[i] + 1) % m;
            else          nq[i] = sat ? ((mq[i] == 0) ? 0 : mq[i] - 1)
                                      : (mq[i] + m - 1) % m;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q[%0d]", i), dut_q(i), nq[i]);
            check($sformatf("wrap[%0d]", i), dut_w(i), et[i]);
            mq[i] = nq[i];
        end
    endtask

    // Asynchronous clear between edges, with a coincident load/en that must be ignored.
    task automatic do_clear();
        clear = 1'b1;
        load  = 1'b1;
        en    = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("clr_q[%0d]", i), dut_q(i), 0);
            check($sformatf("clr_wrap[%0d]", i), dut_w(i), 0);
            mq[i] = 0;
        end
        clear = 1'b0;
    endtask

    initial begin
        int tcp;
        int sat_q[4];
        int sat_w[4];

        clear = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
        for (int i = 0; i < 3; i++) mq[i] = 0;
        #1;
        check("reset_q0", int'(q0), 0);
        check("reset_wrap0", int'(w0), 0);
        @(posedge clk);
        #1;
        clear = 1'b0;

        // Up-count wrap, load-then-down wrap, load clamp, hold.
        for (int k = 1; k <= 9; k++) tbl.push_back(mk(1, 1, 0, 4'd0, k, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'd0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 4'd0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'd0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4'd2, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4'd0, 9, 1, 1));
        tbl.push_back(mk(1, 0, 0, 4'd0, 8, 0, 0));
        tbl.push_back(mk(1, 1, 1, 4'd13, 9, 0, 0));
        tbl.push_back(mk(1, 1, 1, 4'd3, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'd0, 3, 0, 0));
        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].dv, tcp);
            check($sformatf("tbl%0d_tc", k), tcp, tbl[k].etc);
            check($sformatf("tbl%0d_q", k), int'(q0), tbl[k].eq);
            check($sformatf("tbl%0d_wrap", k), int'(w0), tbl[k].ew);
        end

        // Clear mid-count from q=7, then counting resumes on the first edge after release.
        cycle(1'b0, 1'b1, 1'b1, 4'd7, tcp);
        check("pre_clear_q0", int'(q0), 7);
        do_clear();
        cycle(1'b1, 1'b1, 1'b0, 4'd0, tcp);
        check("post_clear_q0", int'(q0), 1);

        // Saturation: up from 8 blocks at 9 with wrap on each blocked edge, then step down.
        sat_q = '{9, 9, 9, 8};
        sat_w = '{0, 1, 1, 0};
        cycle(1'b0, 1'b1, 1'b1, 4'd8, tcp);
        check("sat_load_q1", int'(q1), 8);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, (k < 3), 1'b0, 4'd0, tcp);
            check($sformatf("sat%0d_q1", k), int'(q1), sat_q[k]);
            check($sformatf("sat%0d_wrap1", k), int'(w1), sat_w[k]);
        end

        // Full-range mod-8: 7 -> 0 without overflow, then hold with en low.
        cycle(1'b0, 1'b1, 1'b1, 4'd7, tcp);
        check("full_load_q2", int'(q2), 7);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, tcp);
        check("full_wrap_q2", int'(q2), 0);
        check("full_wrap_w2", int'(w2), 1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd0, tcp);
            check($sformatf("full_hold%0d_q2", k), int'(q2), 0);
            check($sformatf("full_hold%0d_w2", k), int'(w2), 0);
            check($sformatf("full_hold%0d_tc2", k), int'(tc2), 0);
        end

        // Randomized traffic against the model, with occasional asynchronous clears.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0) do_clear();
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), tcp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_mod_counter.md
Name: sync_mod_counter

Overview:
- Parametrised synchronous modulo-N up/down counter with parallel load, count enable and terminal-count outputs.
- Successor to the single-bit T/D flip-flop primitives: generalises one toggle stage to a WIDTH-bit counter.
- Adds direction control, programmable modulus, optional saturation and a registered wrap flag.
- Used as the standard divider/event counter in timing and sequencing blocks.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..16.
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends of the range.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- clear  input  1  asynchronous, active-high reset.
- en  input  1  count enable; sampled on the rising edge of clk.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count value, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse on a wrap or saturation hit.

Behaviour:
- Reset: clear=1 forces q=0 and wrap=0 immediately, independent of clk. Both stay 0 while clear is held. Counting resumes on the first rising edge after clear deasserts.
- Priority at each rising edge of clk: clear > load > en > hold.
- load=1: q <= d if d <= MODULUS-1, otherwise q <= MODULUS-1 (clamped).
  - Load ignores en and up.
  - wrap <= 0 on a load cycle.
- load=0, en=1, up=1:
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1, SATURATE=0: q <= 0.
  - q == MODULUS-1, SATURATE=1: q holds.
- load=0, en=1, up=0:
  - q > 0: q <= q-1.
  - q == 0, SATURATE=0: q <= MODULUS-1.
  - q == 0, SATURATE=1: q holds at 0.
- load=0, en=0: q holds and wrap <= 0.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
  - Purely combinational, so it can be used for cascading counters.
- wrap:
  - Set to 1 for exactly one cycle on any edge where tc was 1 (wrap or saturation hit). Otherwise 0.
  - Changes on the same edge that updates q, i.e. 0 cycles of latency relative to q.
  - Under SATURATE=1 with en held at the end of the range, wrap stays high every cycle. It is high once per blocked step, not a single pulse.
- Direction change mid-count takes effect on the next edge with no dead cycle.
- Arithmetic: all compares are unsigned. Internal next-state logic must not overflow WIDTH when MODULUS = 2**WIDTH; wrap detection uses the compare, never a carry-out.
- q never leaves 0..MODULUS-1, including after any load value.
- Reset mid-operation: clear asserted between edges zeroes q and wrap immediately. A coincident load or en is ignored.

Test Plan:
- Reset check: clear=1 with q=7 mid-count -> q=0 and wrap=0 before the next clk edge; with en=1, up=1, q=1 on the first edge after release.
- Up count, WIDTH=4, MODULUS=10, SATURATE=0, en=1, up=1, 12 edges from 0 -> q = 1..9, 0, 1, 2; tc=1 only while q=9; wrap=1 only in the cycle where q=0 after the wrap.
- Down count from load d=2, up=0, en=1 -> q = 2, 1, 0, 9, 8; tc=1 at q=0; wrap pulses once, coincident with q=9.
- Load priority and clamp: load=1, en=1, d=4'd13 -> q=9 (clamped), wrap=0; then load=1, d=3 -> q=3.
- Saturation, SATURATE=1, up=1, en=1 from q=8 -> q = 9, 9, 9; wrap=1 on each blocked edge; then up=0 -> q=8 on the next edge and wrap=0.
- Full-range corner, WIDTH=3, MODULUS=8: up-count from 7 -> q=0 with no X or overflow; en=0 for 3 edges -> q holds, tc=0, wrap=0.
